// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - streaming KHxKWxD sliding-window generator for the convolution filters
// Optional build macro: WINDOW_STRIDE2_EN (emit only even-row/even-col windows, strided indices)
module conv_window_feeder #(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int INPUT_WIDTH   = 4,
  parameter int INPUT_HEIGHT  = 4,
  parameter int INPUT_DEPTH   = 1,
  parameter int VALUE_BITS    = 32,
  localparam int WIN_SIZE     = KERNEL_HEIGHT * KERNEL_WIDTH * INPUT_DEPTH,
  localparam int OUT_HEIGHT   = INPUT_HEIGHT - KERNEL_HEIGHT + 1,
  localparam int OUT_WIDTH    = INPUT_WIDTH - KERNEL_WIDTH + 1,
  localparam int ROW_BITS     = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1,
  localparam int COL_BITS     = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [VALUE_BITS-1:0] win_data [WIN_SIZE],
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [ROW_BITS-1:0]   win_row,
  output logic [COL_BITS-1:0]   win_col,
  output logic                  win_last
);

  localparam int SR_LEN  = ((KERNEL_HEIGHT - 1) * INPUT_WIDTH + KERNEL_WIDTH) * INPUT_DEPTH;
  localparam int CH_W    = (INPUT_DEPTH > 1) ? $clog2(INPUT_DEPTH) : 1;
  localparam int COL_W   = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int ROW_W   = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;

  logic [CH_W-1:0]       ch;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [VALUE_BITS-1:0] sr   [SR_LEN];
  logic [VALUE_BITS-1:0] cand [WIN_SIZE];

  logic                  accept;
  logic                  ch_end;
  logic                  col_end;
  logic                  row_end;
  logic                  completing;
  logic                  emit;
  logic                  is_last;
  logic [ROW_W-1:0]      orow;
  logic [COL_W-1:0]      ocol;
  logic [ROW_BITS-1:0]   next_row;
  logic [COL_BITS-1:0]   next_col;

  assign in_ready   = !rst && (!win_valid || win_ready);
  assign accept     = in_valid && in_ready;
  assign ch_end     = (ch == CH_W'(INPUT_DEPTH - 1));
  assign col_end    = (col == COL_W'(INPUT_WIDTH - 1));
  assign row_end    = (row == ROW_W'(INPUT_HEIGHT - 1));
  assign completing = ch_end && (row >= ROW_W'(KERNEL_HEIGHT - 1)) && (col >= COL_W'(KERNEL_WIDTH - 1));

  // Top-left corner of the window that the incoming beat completes.
  assign orow = row - ROW_W'(KERNEL_HEIGHT - 1);
  assign ocol = col - COL_W'(KERNEL_WIDTH - 1);

`ifdef WINDOW_STRIDE2_EN
  assign emit     = completing && !orow[0] && !ocol[0];
  assign is_last  = (orow == ROW_W'(2 * ((OUT_HEIGHT - 1) / 2))) &&
                    (ocol == COL_W'(2 * ((OUT_WIDTH - 1) / 2)));
  assign next_row = ROW_BITS'(orow >> 1);
  assign next_col = COL_BITS'(ocol >> 1);
`else
  assign emit     = completing;
  assign is_last  = row_end && col_end;
  assign next_row = ROW_BITS'(orow);
  assign next_col = COL_BITS'(ocol);
`endif

  // Element (t,m,n) sits at a fixed age in the stream; age 0 is the beat being accepted.
  for (genvar t = 0; t < KERNEL_HEIGHT; t++) begin : g_t
    for (genvar m = 0; m < KERNEL_WIDTH; m++) begin : g_m
      for (genvar n = 0; n < INPUT_DEPTH; n++) begin : g_n
        localparam int E   = t * KERNEL_WIDTH * INPUT_DEPTH + m * INPUT_DEPTH + n;
        localparam int AGE = ((KERNEL_HEIGHT - 1 - t) * INPUT_WIDTH + (KERNEL_WIDTH - 1 - m)) * INPUT_DEPTH
                             + (INPUT_DEPTH - 1 - n);
        if (AGE == 0) begin : g_new
          assign cand[E] = in_data;
        end else begin : g_old
          assign cand[E] = sr[AGE-1];
        end
      end
    end
  end

  // Line buffer holds only stream history, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr[0] <= in_data;
      for (int i = 1; i < SR_LEN; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        win_data[i] <= '0;
      end
    end else begin
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
      if (accept) begin
        if (ch_end) begin
          ch <= '0;
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          ch <= ch + 1'b1;
        end
        if (emit) begin
          for (int i = 0; i < WIN_SIZE; i++) begin
            win_data[i] <= cand[i];
          end
          win_row   <= next_row;
          win_col   <= next_col;
          win_last  <= is_last;
          win_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - scoreboard bench for conv_window_feeder (default and WINDOW_STRIDE2_EN builds)
module tb_conv_window_feeder;

`ifdef WINDOW_STRIDE2_EN
  localparam int A_IW = 6;
  localparam int A_IH = 6;
`else
  localparam int A_IW = 4;
  localparam int A_IH = 4;
`endif
  localparam int A_NB = A_IW * A_IH;
  localparam int A_OH = A_IH - 2;
  localparam int A_OW = A_IW - 2;
  localparam int A_RB = (A_OH > 1) ? $clog2(A_OH) : 1;
  localparam int A_CB = (A_OW > 1) ? $clog2(A_OW) : 1;
  localparam int B_NB = 3 * 3 * 2;

  typedef struct packed {
    logic [287:0] data;
    int           row;
    int           col;
    bit           last;
    int           due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in_data = '0, b_in_data = '0;
  logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic        a_in_ready, b_in_ready;
  logic [31:0] a_wd [9];
  logic [31:0] b_wd [8];
  logic        a_wv, b_wv;
  logic        a_wr = 1'b1, b_wr = 1'b1;
  logic [A_RB-1:0] a_row;
  logic [A_CB-1:0] a_col;
  logic [0:0]  b_row, b_col;
  logic        a_last, b_last;

  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tbl_a [4][9];
  int   cb_a  [4];
  int   tbl_b [4][8];
  int   cb_b  [4];
  logic a_hs = 1'b0, a_pv = 1'b0, b_hs = 1'b0, b_pv = 1'b0;
  event stall_ev;

  conv_window_feeder #(
    .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .INPUT_WIDTH(A_IW), .INPUT_HEIGHT(A_IH),
    .INPUT_DEPTH(1), .VALUE_BITS(32)
  ) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .win_data(a_wd), .win_valid(a_wv), .win_ready(a_wr), .win_row(a_row), .win_col(a_col),
    .win_last(a_last)
  );

  conv_window_feeder #(
    .KERNEL_WIDTH(2), .KERNEL_HEIGHT(2), .INPUT_WIDTH(3), .INPUT_HEIGHT(3),
    .INPUT_DEPTH(2), .VALUE_BITS(32)
  ) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .win_data(b_wd), .win_valid(b_wv), .win_ready(b_wr), .win_row(b_row), .win_col(b_col),
    .win_last(b_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic chk_d(input string nm, input logic [287:0] act, input logic [287:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push(input bit is_b, input int j, input int base, input int due);
    exp_t x;
    x = '0;
    if (is_b) begin
      for (int e = 0; e < 8; e++) x.data[e*32 +: 32] = 32'(tbl_b[j][e] + base);
    end else begin
      for (int e = 0; e < 9; e++) x.data[e*32 +: 32] = 32'(tbl_a[j][e] + base);
    end
    x.row  = j / 2;
    x.col  = j % 2;
    x.last = (j == 3);
    x.due  = due;
    if (is_b) qb.push_back(x);
    else      qa.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send(input bit is_b, input logic [31:0] v, output int due);
    int n;
    n = 0;
    if (is_b) begin b_in_data = v; b_in_valid = 1'b1; end
    else      begin a_in_data = v; a_in_valid = 1'b1; end
    @(negedge clk);
    while (!(is_b ? b_in_ready : a_in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(is_b ? b_in_ready : a_in_ready)) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
    end
    due = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic stream_a(input int nframes, input int stall_at);
    int due;
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < A_NB; k++) begin
        send(1'b0, 32'(f * 100 + k), due);
        for (int j = 0; j < 4; j++) if (cb_a[j] == k) push(1'b0, j, f * 100, due);
        if (f == 0 && k == stall_at) begin
          a_wr = 1'b0;
          -> stall_ev;
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic stream_b();
    int due;
    for (int k = 0; k < B_NB; k++) begin
      send(1'b1, 32'(k), due);
      for (int j = 0; j < 4; j++) if (cb_b[j] == k) push(1'b1, j, 0, due);
    end
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(stall_ev);
      repeat (5) begin
        @(negedge clk);
        chk_i("stall_in_ready", int'(a_in_ready), 0);
        chk_i("stall_win_valid", int'(a_wv), 1);
      end
      @(posedge clk);
      #1 a_wr = 1'b1;
    end
  end

  always @(posedge clk) begin
    a_hs <= a_wv && a_wr;
    a_pv <= a_wv;
    b_hs <= b_wv && b_wr;
    b_pv <= b_wv;
  end

  always @(negedge clk) begin : mon_a
    logic [287:0] got;
    got = '0;
    for (int e = 0; e < 9; e++) got[e*32 +: 32] = a_wd[e];
    if (a_wv) begin
      if (!a_pv || a_hs) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_window: got %0h expected none", got);
        end else begin
          cur_a = qa.pop_front();
          chk_d("a_data", got, cur_a.data);
          chk_i("a_row", int'(a_row), cur_a.row);
          chk_i("a_col", int'(a_col), cur_a.col);
          chk_i("a_last", int'(a_last), int'(cur_a.last));
          chk_i("a_latency", cyc, cur_a.due);
        end
      end else begin
        chk_d("a_hold_data", got, cur_a.data);
        chk_i("a_hold_row", int'(a_row), cur_a.row);
        chk_i("a_hold_col", int'(a_col), cur_a.col);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [287:0] got;
    got = '0;
    for (int e = 0; e < 8; e++) got[e*32 +: 32] = b_wd[e];
    if (b_wv && (!b_pv || b_hs)) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_window: got %0h expected none", got);
      end else begin
        cur_b = qb.pop_front();
        chk_d("b_data", got, cur_b.data);
        chk_i("b_row", int'(b_row), cur_b.row);
        chk_i("b_col", int'(b_col), cur_b.col);
        chk_i("b_last", int'(b_last), int'(cur_b.last));
        chk_i("b_latency", cyc, cur_b.due);
      end
    end
  end

  initial begin
    int due;
`ifdef WINDOW_STRIDE2_EN
    tbl_a = '{'{0, 1, 2, 6, 7, 8, 12, 13, 14}, '{2, 3, 4, 8, 9, 10, 14, 15, 16},
              '{12, 13, 14, 18, 19, 20, 24, 25, 26}, '{14, 15, 16, 20, 21, 22, 26, 27, 28}};
    cb_a  = '{14, 16, 26, 28};
`else
    tbl_a = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10}, '{1, 2, 3, 5, 6, 7, 9, 10, 11},
              '{4, 5, 6, 8, 9, 10, 12, 13, 14}, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
    cb_a  = '{10, 11, 14, 15};
`endif
    tbl_b = '{'{0, 1, 2, 3, 6, 7, 8, 9}, '{2, 3, 4, 5, 8, 9, 10, 11},
              '{6, 7, 8, 9, 12, 13, 14, 15}, '{8, 9, 10, 11, 14, 15, 16, 17}};
    cb_b  = '{9, 11, 15, 17};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_in_ready", int'(a_in_ready), 0);
    chk_i("rst_win_valid", int'(a_wv), 0);
    chk_i("rst_win_last", int'(a_last), 0);
    chk_i("rst_win_row", int'(a_row), 0);
    chk_i("rst_win_col", int'(a_col), 0);
    chk_i("rst_win_data0", int'(a_wd[0]), 0);
    chk_i("rst_win_data8", int'(a_wd[8]), 0);
    chk_i("rst_b_in_ready", int'(b_in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    stream_a(1, -1);
    drain();
    stream_a(1, cb_a[0]);
    drain();
`ifndef WINDOW_STRIDE2_EN
    stream_b();
    drain();
`endif
    stream_a(2, -1);
    drain();

    for (int k = 0; k < 7; k++) send(1'b0, 32'(500 + k), due);
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_i("midrst_in_ready", int'(a_in_ready), 0);
    chk_i("midrst_win_valid", int'(a_wv), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    stream_a(1, -1);
    drain();

    chk_i("a_queue_empty", qa.size(), 0);
    chk_i("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
